// File: rtl/approx_err_pkg.sv
// approx_err_pkg: shared state encoding and default widths for the approximate-multiplier error accumulator
package approx_err_pkg;
  localparam int W = 8;
  localparam int CNT_W = 17;
  localparam int SUM_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/approx_err_dp.sv
// approx_err_dp: S1 operand/exact-product register feeding S2 error accumulators
module approx_err_dp #(
  parameter int W = 8,
  parameter int CNT_W = 17,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2*W-1:0]   r_approx,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] sum_abs_err,
  output logic [2*W-1:0]   max_abs_err,
  output logic [W-1:0]     max_a,
  output logic [W-1:0]     max_b,
  output logic             sat
);
  // One spare bit above the wider of sum and error so overflow is always visible
  localparam int AW = (SUM_W > 2*W ? SUM_W : 2*W) + 1;
  logic           s1_vld;
  logic [W-1:0]   s1_a, s1_b;
  logic [2*W-1:0] s1_r, s1_exact, e;
  logic [AW-1:0]  tot;
  logic           ovf;
  always_comb begin
    e = s1_exact >= s1_r ? s1_exact - s1_r : s1_r - s1_exact;
    tot = AW'(sum_abs_err) + AW'(e);
    ovf = |tot[AW-1:SUM_W];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_r <= '0;
      s1_exact <= '0;
      err_count <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      max_a <= '0;
      max_b <= '0;
      sat <= 1'b0;
    end else if (clear) begin
      s1_vld <= 1'b0;
      err_count <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      max_a <= '0;
      max_b <= '0;
      sat <= 1'b0;
    end else begin
      s1_vld <= load;
      if (load) begin
        s1_a <= a;
        s1_b <= b;
        s1_r <= r_approx;
        s1_exact <= (2*W)'(a) * (2*W)'(b);
      end
      if (s1_vld) begin
        if (e != '0) err_count <= err_count + CNT_W'(1);
        sum_abs_err <= ovf ? '1 : tot[SUM_W-1:0];
        sat <= sat | ovf;
        // Strict compare keeps the earliest sample on ties
        if (e > max_abs_err) begin
          max_abs_err <= e;
          max_a <= s1_a;
          max_b <= s1_b;
        end
      end
    end
endmodule

// File: rtl/approx_err_acc.sv
// approx_err_acc: run-control FSM, sample counter and handshake around the error-metric datapath
module approx_err_acc #(
  parameter int W = approx_err_pkg::W,
  parameter int CNT_W = approx_err_pkg::CNT_W,
  parameter int SUM_W = approx_err_pkg::SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2*W-1:0]   r_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] sum_abs_err,
  output logic [2*W-1:0]   max_abs_err,
  output logic [W-1:0]     max_a,
  output logic [W-1:0]     max_b,
  output logic             sat
);
  import approx_err_pkg::*;
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, n_lat;
  logic             acc, last, go;
  always_comb begin
    go = state == IDLE && start;
    acc = in_valid && in_ready;
    last = cnt + CNT_W'(1) == n_lat;
    nxt = state == IDLE  ? (start ? (n_samples != '0 ? RUN : DRAIN) : IDLE) :
          state == RUN   ? (acc && last ? DRAIN : RUN) :
          state == DRAIN ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      n_lat <= '0;
    end else if (go) begin
      cnt <= '0;
      n_lat <= n_samples;
    end else if (acc) cnt <= cnt + CNT_W'(1);
  assign in_ready = state == RUN;
  assign busy = state != IDLE;
  assign done = state == DONE;
  approx_err_dp #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_dp (
    .clk(clk),
    .rst_n(rst_n),
    .clear(go),
    .load(acc),
    .a(a),
    .b(b),
    .r_approx(r_approx),
    .err_count(err_count),
    .sum_abs_err(sum_abs_err),
    .max_abs_err(max_abs_err),
    .max_a(max_a),
    .max_b(max_b),
    .sat(sat)
  );
endmodule

// File: tb/tb_approx_err_acc.sv
// tb_approx_err_acc: directed checks of the error accumulator, plus a narrow-sum instance for saturation
module tb_approx_err_acc;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, in_valid = 1'b0;
  logic [16:0] n_samples = '0;
  logic [7:0]  a = '0, b = '0;
  logic [15:0] r_approx = '0;
  logic        in_ready, busy, done, sat;
  logic [16:0] err_count;
  logic [31:0] sum_abs_err;
  logic [15:0] max_abs_err;
  logic [7:0]  max_a, max_b;
  logic        s_start = 1'b0, s_valid = 1'b0;
  logic [16:0] s_n = '0;
  logic [7:0]  s_a = '0, s_b = '0;
  logic [15:0] s_r = '0;
  logic        s_ready, s_busy, s_done, s_sat;
  logic [16:0] s_err;
  logic [7:0]  s_sum;
  logic [15:0] s_max;
  logic [7:0]  s_ma, s_mb;
  int vectors = 0, miscompares = 0;
  logic [7:0] pat;

  always #5 clk = ~clk;

  approx_err_acc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .r_approx(r_approx),
    .busy(busy), .done(done), .err_count(err_count), .sum_abs_err(sum_abs_err),
    .max_abs_err(max_abs_err), .max_a(max_a), .max_b(max_b), .sat(sat)
  );

  approx_err_acc #(.SUM_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .n_samples(s_n),
    .in_valid(s_valid), .in_ready(s_ready), .a(s_a), .b(s_b), .r_approx(s_r),
    .busy(s_busy), .done(s_done), .err_count(s_err), .sum_abs_err(s_sum),
    .max_abs_err(s_max), .max_a(s_ma), .max_b(s_mb), .sat(s_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n);
    start = 1'b1;
    n_samples = 17'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int va, input int vb, input int vr);
    int t = 0;
    a = 8'(va);
    b = 8'(vb);
    r_approx = 16'(vr);
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 20) begin
      tick();
      t++;
    end
    chk({tag, "_done"}, 32'(done), 1);
  endtask

  task automatic check_res(input string tag, input int ec, input int s, input int m,
                           input int ma, input int mb, input int st);
    chk({tag, "_err_count"}, 32'(err_count), ec);
    chk({tag, "_sum"}, sum_abs_err, s);
    chk({tag, "_max"}, 32'(max_abs_err), m);
    chk({tag, "_max_a"}, 32'(max_a), ma);
    chk({tag, "_max_b"}, 32'(max_b), mb);
    chk({tag, "_sat"}, 32'(sat), st);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_done", 32'(done), 0);
    check_res("rst", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // three samples, only the middle one is wrong by 4
    start_run(3);
    chk("t1_ready", 32'(in_ready), 1);
    send(3, 5, 15);
    send(10, 10, 96);
    send(255, 255, 65025);
    chk("t1_ready_drop", 32'(in_ready), 0);
    wait_done("t1");
    check_res("t1", 1, 4, 4, 10, 10, 0);
    tick();
    chk("t1_done_once", 32'(done), 0);
    chk("t1_idle", 32'(busy), 0);

    // overestimate gives a positive error as well
    start_run(1);
    send(2, 2, 7);
    wait_done("t2");
    check_res("t2", 1, 3, 3, 2, 2, 0);
    tick();

    // equal errors: the first sample keeps the max
    start_run(2);
    send(4, 4, 14);
    send(1, 2, 0);
    wait_done("t3");
    check_res("t3", 2, 4, 2, 4, 4, 0);
    tick();

    // gapped valid, with start pulses during RUN and DONE that must be ignored
    pat = 8'b1110_1101;
    start_run(4);
    for (int i = 0; i < 8; i++) begin
      in_valid = pat[i];
      a = 8'(i + 1);
      b = 8'd2;
      r_approx = 16'd0;
      start = (i == 2 || i == 7);
      n_samples = 17'd1;
      if (i >= 6) chk($sformatf("t4_ready_low_%0d", i), 32'(in_ready), 0);
      if (i == 7) chk("t4_done", 32'(done), 1);
      tick();
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("t4_idle", 32'(busy), 0);
    check_res("t4", 4, 28, 12, 6, 2, 0);

    // zero-length run
    start_run(0);
    chk("t5_done_early", 32'(done), 0);
    tick();
    chk("t5_done", 32'(done), 1);
    check_res("t5", 0, 0, 0, 0, 0, 0);
    tick();

    // narrow sum saturates on the first 65025 error and stays clamped
    s_start = 1'b1;
    s_n = 17'd2;
    tick();
    s_start = 1'b0;
    s_a = 8'd255;
    s_b = 8'd255;
    s_r = 16'd0;
    s_valid = 1'b1;
    repeat (2) tick();
    s_valid = 1'b0;
    tick();
    chk("t6_done", 32'(s_done), 1);
    chk("t6_sum", 32'(s_sum), 255);
    chk("t6_sat", 32'(s_sat), 1);
    chk("t6_err", 32'(s_err), 2);
    chk("t6_max", 32'(s_max), 65025);

    // reset mid-run wipes everything, then a clean run follows
    start_run(3);
    send(2, 2, 7);
    rst_n = 1'b0;
    #2;
    chk("t7_busy", 32'(busy), 0);
    chk("t7_ready", 32'(in_ready), 0);
    check_res("t7", 0, 0, 0, 0, 0, 0);
    tick();
    check_res("t7b", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    start_run(1);
    send(1, 1, 1);
    wait_done("t8");
    check_res("t8", 0, 0, 0, 0, 0, 0);
    tick();
    chk("t8_done_once", 32'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
